// File: rtl/fifo_rr_arbiter.sv
// Round-robin scheduler that pops one word per cycle from four input FIFOs and
// routes it by destination field into one of four output FIFOs, two cycles after the pop.
module fifo_rr_arbiter #(
  parameter int WORD_SIZE = 10,
  parameter int DEST_LSB  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   arb_en,
  input  logic [3:0]             in_empty,
  input  logic [4*WORD_SIZE-1:0] in_data,
  input  logic [3:0]             out_almost_full,
  output logic [3:0]             in_rd_en,
  output logic [3:0]             out_wr_en,
  output logic [WORD_SIZE-1:0]   out_data,
  output logic [1:0]             grant,
  output logic                   idle
);

  typedef enum logic [1:0] {IDLE, ACTIVE, PAUSE} state_t;

  state_t               state, state_next;
  logic                 stall;
  logic [3:0]           eligible;
  logic                 any_eligible;
  logic [1:0]           pick;
  logic [1:0]           cand;
  logic                 pop;
  logic [3:0]           rd_sel;
  logic                 sel_valid;
  logic [WORD_SIZE-1:0] sel_word;
  logic [1:0]           sel_dest;

  assign stall        = |out_almost_full;
  assign eligible     = ~in_empty & ~in_rd_en;
  assign any_eligible = |eligible;

  // Later overwrites win, so scanning from grant+4 down to grant+1 leaves the nearest eligible index.
  always_comb begin
    pick = grant;
    cand = grant;
    for (int n = 4; n >= 1; n--) begin
      cand = grant + 2'(n);
      if (eligible[cand]) pick = cand;
    end
  end

  always_comb begin
    state_next = state;
    if (arb_en && stall) begin
      state_next = PAUSE;
    end else begin
      case (state)
        IDLE:    if (arb_en && any_eligible) state_next = ACTIVE;
        ACTIVE:  if (!arb_en || !any_eligible) state_next = IDLE;
        PAUSE:   if (!stall) state_next = (arb_en && any_eligible) ? ACTIVE : IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  assign pop = (state_next == ACTIVE);

  // rd_sel is the pop strobe delayed one cycle, marking which FIFO's data_out is now valid.
  always_comb begin
    sel_word = '0;
    for (int i = 0; i < 4; i++) begin
      if (rd_sel[i]) sel_word = in_data[i*WORD_SIZE +: WORD_SIZE];
    end
  end

  assign sel_valid = |rd_sel;
  assign sel_dest  = sel_word[DEST_LSB+1:DEST_LSB];

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_rd_en  <= '0;
      rd_sel    <= '0;
      out_wr_en <= '0;
      out_data  <= '0;
      grant     <= 2'd3;
    end else begin
      state     <= state_next;
      in_rd_en  <= pop ? (4'b0001 << pick) : 4'b0000;
      if (pop) grant <= pick;
      rd_sel    <= in_rd_en;
      out_wr_en <= sel_valid ? (4'b0001 << sel_dest) : 4'b0000;
      if (sel_valid) out_data <= sel_word;
    end
  end

  assign idle = (state == IDLE) && (in_rd_en == 4'b0000) && (rd_sel == 4'b0000)
                && (out_wr_en == 4'b0000);

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench for fifo_rr_arbiter: behavioural input FIFOs feed the DUT and a
// scoreboard queue holds the push expected two cycles after every observed pop.
module tb_fifo_rr_arbiter;

  typedef struct {
    logic [3:0] en;
    logic [9:0] data;
    int         cyc;
  } exp_t;

  typedef struct {
    int idx;
    int cyc;
  } pop_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        arb_en;
  logic [3:0]  in_empty;
  logic [39:0] in_data;
  logic [3:0]  out_almost_full;
  logic [3:0]  in_rd_en;
  logic [3:0]  out_wr_en;
  logic [9:0]  out_data;
  logic [1:0]  grant;
  logic        idle;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         push_cnt = 0;
  exp_t       exp_q[$];
  pop_t       pop_log[$];
  logic [3:0] last_en;
  logic [9:0] last_data;

  int         cnt[4] = '{0, 0, 0, 0};
  int         rp[4]  = '{0, 0, 0, 0};
  logic [9:0] mem[4][64];
  logic [9:0] dq[4] = '{10'h0, 10'h0, 10'h0, 10'h0};

  fifo_rr_arbiter #(.WORD_SIZE(10), .DEST_LSB(8)) dut (
    .clk(clk),
    .reset(reset),
    .arb_en(arb_en),
    .in_empty(in_empty),
    .in_data(in_data),
    .out_almost_full(out_almost_full),
    .in_rd_en(in_rd_en),
    .out_wr_en(out_wr_en),
    .out_data(out_data),
    .grant(grant),
    .idle(idle)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Input FIFO model: registered read data, empty flag follows the stored count.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (in_rd_en[i] && cnt[i] > 0) begin
        dq[i]  <= mem[i][rp[i]];
        rp[i]  <= rp[i] + 1;
        cnt[i] <= cnt[i] - 1;
      end
    end
  end

  always_comb begin
    in_empty = 4'b0000;
    in_data  = '0;
    for (int i = 0; i < 4; i++) begin
      in_empty[i]          = (cnt[i] == 0);
      in_data[i*10 +: 10]  = dq[i];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int f, input logic [9:0] w);
    mem[f][rp[f] + cnt[f]] = w;
    cnt[f] = cnt[f] + 1;
  endtask

  // Scoreboard: log pops, queue their expected pushes, and match pushes as they appear.
  int         mon_k;
  exp_t       mon_e;
  logic [9:0] mon_w;
  always @(negedge clk) begin
    if (in_rd_en != 4'b0000) begin
      checkOutput("rd_onehot", 32'($onehot(in_rd_en)), 1);
      mon_k = 0;
      for (int i = 0; i < 4; i++) if (in_rd_en[i]) mon_k = i;
      checkOutput("pop_nonempty", 32'(cnt[mon_k] > 0), 1);
      if (cnt[mon_k] > 0) begin
        mon_w = mem[mon_k][rp[mon_k]];
        exp_q.push_back('{en: 4'b0001 << mon_w[9:8], data: mon_w, cyc: cyc + 2});
      end
      pop_log.push_back('{idx: mon_k, cyc: cyc});
    end
    if (out_wr_en != 4'b0000) begin
      push_cnt++;
      last_en   = out_wr_en;
      last_data = out_data;
      if (exp_q.size() == 0) begin
        checkOutput("push_unexpected", 32'(out_wr_en), 0);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("push_en", 32'(out_wr_en), 32'(mon_e.en));
        checkOutput("push_data", 32'(out_data), 32'(mon_e.data));
        checkOutput("push_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      mon_e = exp_q.pop_front();
      checkOutput("push_missing", 32'(out_wr_en), 32'(mon_e.en));
    end
  end

  task automatic waitPops(input int n, input string tag);
    logic ok;
    ok = 1'b0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk); #1;
      if (pop_log.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput(tag, 32'(ok), 1);
  endtask

  task automatic waitDrain(input string tag);
    logic ok;
    ok = 1'b0;
    for (int t = 0; t < 80; t++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0 && idle === 1'b1 && in_rd_en == 4'b0000 &&
          cnt[0] == 0 && cnt[1] == 0 && cnt[2] == 0 && cnt[3] == 0) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput(tag, 32'(ok), 1);
  endtask

  int cs;
  int sz0;
  int p0;
  int last_idx;
  int base;

  initial begin
    reset           = 1'b1;
    arb_en          = 1'b1;
    out_almost_full = 4'b0000;

    // Reset with FIFO0 holding a word
    applyStimulus(0, 10'h011);
    repeat (2) begin
      @(negedge clk); #1;
      checkOutput("t1_rd_en", 32'(in_rd_en), 0);
      checkOutput("t1_wr_en", 32'(out_wr_en), 0);
      checkOutput("t1_grant", 32'(grant), 3);
      checkOutput("t1_idle", 32'(idle), 1);
      checkOutput("t1_data", 32'(out_data), 0);
    end
    reset = 1'b0;
    waitPops(1, "t1_pop_seen");
    checkOutput("t1_first_pop", 32'(pop_log[0].idx), 0);
    waitDrain("t1_drain");

    // Round robin across four loaded FIFOs; grant is 0 so the sequence starts at 1
    pop_log.delete();
    for (int f = 0; f < 4; f++)
      for (int j = 0; j < 3; j++)
        applyStimulus(f, {2'(f), 8'(f * 16 + j)});
    waitPops(12, "t2_pops_seen");
    if (pop_log.size() >= 12) begin
      for (int n = 0; n < 12; n++) begin
        checkOutput("t2_rr_idx", 32'(pop_log[n].idx), 32'((n + 1) % 4));
        checkOutput("t2_rr_cycle", 32'(pop_log[n].cyc), 32'(pop_log[0].cyc + n));
      end
    end
    waitDrain("t2_drain");

    // Single FIFO with two words: pops two cycles apart, exactly two pushes
    pop_log.delete();
    p0 = push_cnt;
    applyStimulus(2, 10'h2C1);
    applyStimulus(2, 10'h1C2);
    waitDrain("t3_drain");
    checkOutput("t3_pop_count", 32'(pop_log.size()), 2);
    if (pop_log.size() == 2) begin
      checkOutput("t3_idx0", 32'(pop_log[0].idx), 2);
      checkOutput("t3_idx1", 32'(pop_log[1].idx), 2);
      checkOutput("t3_gap", 32'(pop_log[1].cyc - pop_log[0].cyc), 2);
    end
    checkOutput("t3_push_count", 32'(push_cnt - p0), 2);

    // Routing by destination field
    pop_log.delete();
    applyStimulus(1, 10'h3A5);
    waitDrain("t4_drain");
    checkOutput("t4_pop_count", 32'(pop_log.size()), 1);
    if (pop_log.size() == 1) checkOutput("t4_pop_idx", 32'(pop_log[0].idx), 1);
    checkOutput("t4_wr_en", 32'(last_en), 32'h8);
    checkOutput("t4_data", 32'(last_data), 32'h3A5);

    // Backpressure mid-stream, then release
    pop_log.delete();
    for (int f = 0; f < 4; f++)
      for (int j = 0; j < 4; j++)
        applyStimulus(f, {2'((f + j) % 4), 8'(8'h80 + f * 16 + j)});
    waitPops(3, "t5_pops_seen");
    out_almost_full = 4'b0100;
    cs  = cyc;
    sz0 = pop_log.size();
    p0  = push_cnt;
    repeat (6) @(negedge clk);
    #1;
    checkOutput("t5_no_pop_stalled", 32'(pop_log.size()), 32'(sz0));
    checkOutput("t5_inflight_le2", 32'((push_cnt - p0) <= 2), 1);
    checkOutput("t5_inflight_done", 32'(exp_q.size()), 0);
    checkOutput("t5_not_idle", 32'(idle), 0);
    last_idx = pop_log[pop_log.size() - 1].idx;
    base = pop_log.size();
    out_almost_full = 4'b0000;
    waitPops(base + 1, "t5_resume_seen");
    if (pop_log.size() > base) begin
      checkOutput("t5_resume_idx", 32'(pop_log[base].idx), 32'((last_idx + 1) % 4));
      checkOutput("t5_resume_after", 32'(pop_log[base].cyc > cs + 6), 1);
    end
    waitDrain("t5_drain");

    // Reset the cycle after a pop is issued: the in-flight word is dropped
    pop_log.delete();
    applyStimulus(3, 10'h0F3);
    applyStimulus(3, 10'h0F4);
    begin
      logic seen;
      seen = 1'b0;
      for (int t = 0; t < 20; t++) begin
        @(negedge clk); #1;
        if (in_rd_en != 4'b0000) begin
          seen = 1'b1;
          break;
        end
      end
      checkOutput("t6_pop_seen", 32'(seen), 1);
    end
    reset  = 1'b1;
    arb_en = 1'b0;
    exp_q.delete();
    p0 = push_cnt;
    repeat (2) begin
      @(negedge clk); #1;
      checkOutput("t6_wr_en", 32'(out_wr_en), 0);
      checkOutput("t6_rd_en", 32'(in_rd_en), 0);
      checkOutput("t6_grant", 32'(grant), 3);
      checkOutput("t6_idle", 32'(idle), 1);
      checkOutput("t6_data", 32'(out_data), 0);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("t6_no_push", 32'(push_cnt - p0), 0);
    checkOutput("t6_idle_after", 32'(idle), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
